// File: rtl/uart_port_controller.sv
// Shares one uart TX path between two byte requesters and captures received bytes.
// Keeps sticky overrun, framing-error and TX start-timeout flags.
module uart_port_controller #(
  parameter int ARB_MODE      = 0,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int START_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_is_transmitting,
  input  logic       uart_received,
  input  logic [7:0] uart_rx_byte,
  input  logic       uart_rx_error,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       tx_timeout,
  input  logic       clear_status,
  output logic       tx_busy
);

  // Handshakes: a byte moves when valid & ready are both high at a rising clk edge;
  // valid must not depend on ready, ready may depend on valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(START_TIMEOUT - 1);

  tx_state_t                state;
  tx_state_t                state_next;
  logic                     last_grant;
  logic                     grant;
  logic                     any_valid;
  logic                     can_grant;
  logic                     accept;
  logic                     timeout_hit;
  logic [TIMEOUT_WIDTH-1:0] start_cnt;

  logic       recv_d;
  logic       recv_q;
  logic       err_d;
  logic       err_q;
  logic [7:0] byte_d;
  logic       recv_rise;
  logic       err_rise;
  logic       rx_pop;
  logic       overrun_set;

  // grant selects requester 1 when high; only meaningful while any_valid
  always_comb begin
    grant     = 1'b0;
    any_valid = req0_valid || req1_valid;
    if (ARB_MODE == 1) begin
      grant = !req0_valid && req1_valid;
    end else if (req0_valid && req1_valid) begin
      grant = !last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  assign can_grant   = (state == IDLE) && !uart_is_transmitting && any_valid;
  assign req0_ready  = can_grant && !grant;
  assign req1_ready  = can_grant && grant;
  assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign timeout_hit = (state == START) && !uart_is_transmitting && (start_cnt == TIMEOUT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = START;
      START: begin
        if (uart_is_transmitting) state_next = DONE;
        else if (start_cnt == TIMEOUT_LAST) state_next = IDLE;
      end
      DONE:    if (!uart_is_transmitting) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      uart_tx_byte <= 8'h00;
      start_cnt    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        uart_tx_byte <= grant ? req1_data : req0_data;
        last_grant   <= grant;
      end
      if (state == START) start_cnt <= start_cnt + 1'b1;
      else start_cnt <= '0;
    end
  end

  // Decoded straight from the state register so reset drops transmit asynchronously
  assign uart_transmit = (state == START);
  assign tx_busy       = (state != IDLE);

  assign recv_rise   = recv_d && !recv_q;
  assign err_rise    = err_d && !err_q;
  assign rx_pop      = rx_valid && rx_ready;
  assign overrun_set = recv_rise && rx_valid && !rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recv_d       <= 1'b0;
      recv_q       <= 1'b0;
      err_d        <= 1'b0;
      err_q        <= 1'b0;
      byte_d       <= 8'h00;
      rx_valid     <= 1'b0;
      rx_data      <= 8'h00;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_timeout   <= 1'b0;
    end else begin
      recv_d <= uart_received;
      recv_q <= recv_d;
      err_d  <= uart_rx_error;
      err_q  <= err_d;
      byte_d <= uart_rx_byte;

      if (recv_rise && (!rx_valid || rx_pop)) begin
        rx_data  <= byte_d;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end

      // A set event in the same cycle as clear_status keeps the flag high
      if (overrun_set) rx_overrun <= 1'b1;
      else if (clear_status) rx_overrun <= 1'b0;

      if (err_rise) rx_frame_err <= 1'b1;
      else if (clear_status) rx_frame_err <= 1'b0;

      if (timeout_hit) tx_timeout <= 1'b1;
      else if (clear_status) tx_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_port_controller.sv
// Bench for uart_port_controller: RX vector table, hand-written TX sequences and
// randomized two-requester traffic checked against a byte-order reference.
module tb_uart_port_controller;

  localparam int TW = 8;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       uart_received = 1'b0, uart_rx_error = 1'b0;
  logic [7:0] uart_rx_byte = 8'h00;
  logic       rx_ready = 1'b0, clear_status = 1'b0;
  logic       uart_is_transmitting;

  logic       req0_ready, req1_ready, uart_transmit, rx_valid, rx_overrun;
  logic       rx_frame_err, tx_timeout, tx_busy;
  logic [7:0] uart_tx_byte, rx_data;

  logic       f_req0_ready, f_req1_ready, f_transmit, f_rx_valid, f_rx_overrun;
  logic       f_rx_frame_err, f_tx_timeout, f_tx_busy;
  logic [7:0] f_tx_byte, f_rx_data;

  always #5 clk = ~clk;

  uart_port_controller #(.ARB_MODE(0), .TIMEOUT_WIDTH(TW), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .uart_received(uart_received), .uart_rx_byte(uart_rx_byte), .uart_rx_error(uart_rx_error),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .tx_timeout(tx_timeout),
    .clear_status(clear_status), .tx_busy(tx_busy)
  );

  // Fixed-priority instance shares every input, including the uart model's is_transmitting
  uart_port_controller #(.ARB_MODE(1), .TIMEOUT_WIDTH(TW), .START_TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(f_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(f_req1_ready),
    .uart_transmit(f_transmit), .uart_tx_byte(f_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .uart_received(uart_received), .uart_rx_byte(uart_rx_byte), .uart_rx_error(uart_rx_error),
    .rx_valid(f_rx_valid), .rx_data(f_rx_data), .rx_ready(rx_ready),
    .rx_overrun(f_rx_overrun), .rx_frame_err(f_rx_frame_err), .tx_timeout(f_tx_timeout),
    .clear_status(clear_status), .tx_busy(f_tx_busy)
  );

  // uart model: answers transmit with is_transmitting for a few cycles and logs the byte
  logic       uart_auto = 1'b1;
  logic       manual_tx = 1'b0;
  logic       model_tx = 1'b0;
  logic       rand_frame = 1'b0;
  int         frame_cnt = 0;
  logic [7:0] tx_log[$];

  assign uart_is_transmitting = uart_auto ? model_tx : manual_tx;

  always @(negedge clk) begin
    if (!rst_n || !uart_auto) begin
      model_tx  = 1'b0;
      frame_cnt = 0;
    end else if (model_tx) begin
      if (frame_cnt == 0) model_tx = 1'b0;
      else frame_cnt = frame_cnt - 1;
    end else if (uart_transmit) begin
      model_tx  = 1'b1;
      frame_cnt = rand_frame ? int'($urandom_range(1, 6)) : 3;
      tx_log.push_back(uart_tx_byte);
    end
  end

  int   errors = 0;
  int   checks = 0;
  logic hs0, hs1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: handshakes sampled just before the edge, then return 2ns after it
  task automatic step();
    @(negedge clk);
    #1;
    hs0 = req0_valid & req0_ready;
    hs1 = req1_valid & req1_ready;
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    uart_received = 1'b0; uart_rx_error = 1'b0;
    rx_ready = 1'b0; clear_status = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (tx_busy && n < 200) begin
      step();
      n++;
    end
    check(name, {31'd0, tx_busy}, 32'd0);
  endtask

  typedef struct {
    logic       recv;
    logic [7:0] rbyte;
    logic       err;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ovr;
    logic       e_ferr;
  } rx_vec_t;

  function automatic rx_vec_t mk(logic r, logic [7:0] b, logic e, logic rd, logic c,
                                 logic ev, logic [7:0] ed, logic eo, logic ef);
    rx_vec_t v;
    v.recv = r; v.rbyte = b; v.err = e; v.rdy = rd; v.clr = c;
    v.e_valid = ev; v.e_data = ed; v.e_ovr = eo; v.e_ferr = ef;
    return v;
  endfunction

  rx_vec_t    tbl[22];
  logic [7:0] b0[$], b1[$], exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // recv, byte, err, rdy, clr | valid, data, overrun, frame_err (after the row's clock)
    tbl[0]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 8'h55, 0, 0, 0, 1, 8'h55, 0, 0);
    tbl[3]  = mk(1, 8'h3C, 0, 0, 0, 1, 8'h55, 0, 0);
    tbl[4]  = mk(0, 8'h3C, 0, 0, 0, 1, 8'h55, 1, 0);
    tbl[5]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h55, 1, 0);
    tbl[6]  = mk(0, 8'h00, 0, 0, 1, 0, 8'h55, 0, 0);
    tbl[7]  = mk(1, 8'h55, 0, 0, 0, 0, 8'h55, 0, 0);
    tbl[8]  = mk(0, 8'h55, 0, 0, 0, 1, 8'h55, 0, 0);
    tbl[9]  = mk(1, 8'h3C, 0, 0, 0, 1, 8'h55, 0, 0);
    tbl[10] = mk(0, 8'h3C, 0, 1, 0, 1, 8'h3C, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 1, 0, 0, 8'h3C, 0, 0);
    tbl[12] = mk(1, 8'hA5, 1, 0, 0, 0, 8'h3C, 0, 0);
    tbl[13] = mk(0, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 1);
    tbl[14] = mk(0, 8'h00, 1, 0, 1, 1, 8'hA5, 0, 0);
    tbl[15] = mk(0, 8'h00, 0, 0, 1, 1, 8'hA5, 0, 1);
    tbl[16] = mk(0, 8'h00, 0, 1, 0, 0, 8'hA5, 0, 1);
    tbl[17] = mk(0, 8'h00, 0, 0, 1, 0, 8'hA5, 0, 0);
    tbl[18] = mk(1, 8'h77, 0, 0, 0, 0, 8'hA5, 0, 0);
    tbl[19] = mk(1, 8'h77, 0, 0, 0, 1, 8'h77, 0, 0);
    tbl[20] = mk(1, 8'h88, 0, 0, 0, 1, 8'h77, 0, 0);
    tbl[21] = mk(0, 8'h88, 0, 0, 0, 1, 8'h77, 0, 0);

    // Reset values, checked while reset is still held
    step();
    check("rst_req0_ready", {31'd0, req0_ready}, 0);
    check("rst_req1_ready", {31'd0, req1_ready}, 0);
    check("rst_transmit", {31'd0, uart_transmit}, 0);
    check("rst_tx_byte", {24'd0, uart_tx_byte}, 0);
    check("rst_rx_valid", {31'd0, rx_valid}, 0);
    check("rst_rx_data", {24'd0, rx_data}, 0);
    check("rst_flags", {29'd0, rx_overrun, rx_frame_err, tx_timeout}, 0);
    check("rst_tx_busy", {31'd0, tx_busy}, 0);
    apply_reset();

    // RX capture / overrun / framing vectors
    foreach (tbl[i]) begin
      uart_received = tbl[i].recv;
      uart_rx_byte  = tbl[i].rbyte;
      uart_rx_error = tbl[i].err;
      rx_ready      = tbl[i].rdy;
      clear_status  = tbl[i].clr;
      step();
      check($sformatf("rx%0d_valid", i), {31'd0, rx_valid}, {31'd0, tbl[i].e_valid});
      check($sformatf("rx%0d_data", i), {24'd0, rx_data}, {24'd0, tbl[i].e_data});
      check($sformatf("rx%0d_overrun", i), {31'd0, rx_overrun}, {31'd0, tbl[i].e_ovr});
      check($sformatf("rx%0d_frame_err", i), {31'd0, rx_frame_err}, {31'd0, tbl[i].e_ferr});
    end
    uart_received = 1'b0; rx_ready = 1'b0; clear_status = 1'b0;

    // Single byte from req0
    begin
      int base;
      apply_reset();
      base = tx_log.size();
      req0_valid = 1'b1; req0_data = 8'hAA;
      #1;
      check("t1_req0_ready", {31'd0, req0_ready}, 1);
      check("t1_req1_ready", {31'd0, req1_ready}, 0);
      step();
      check("t1_accept", {31'd0, hs0}, 1);
      req0_valid = 1'b0;
      check("t1_transmit", {31'd0, uart_transmit}, 1);
      check("t1_tx_byte", {24'd0, uart_tx_byte}, 32'hAA);
      wait_idle("t1_idle");
      check("t1_log_count", tx_log.size() - base, 1);
      if (tx_log.size() > base) check("t1_log_byte", {24'd0, tx_log[base]}, 32'hAA);
    end

    // Both requesters held valid: round-robin vs fixed priority
    begin
      int base, n, fp_starts, fp_bad_ready, fp_bad_byte;
      logic [7:0] rr_exp[4];
      rr_exp[0] = 8'h11; rr_exp[1] = 8'h22; rr_exp[2] = 8'h11; rr_exp[3] = 8'h22;
      apply_reset();
      base = tx_log.size();
      fp_starts = 0; fp_bad_ready = 0; fp_bad_byte = 0; n = 0;
      req0_valid = 1'b1; req0_data = 8'h11;
      req1_valid = 1'b1; req1_data = 8'h22;
      while ((tx_log.size() - base) < 4 && n < 200) begin
        step();
        n++;
        if (f_req1_ready) fp_bad_ready++;
        if (f_transmit) begin
          fp_starts++;
          if (f_tx_byte != 8'h11) fp_bad_byte++;
        end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle("t2_idle");
      check("t2_log_count", tx_log.size() - base, 4);
      for (int k = 0; k < 4; k++)
        if (tx_log.size() > base + k)
          check($sformatf("t2_rr_byte%0d", k), {24'd0, tx_log[base + k]}, {24'd0, rr_exp[k]});
      check("t2_fp_req1_ready", fp_bad_ready, 0);
      check("t2_fp_bytes", fp_bad_byte, 0);
      check("t2_fp_starts", fp_starts, 4);
    end

    // uart never starts: timeout after TO cycles in START
    begin
      int n;
      apply_reset();
      uart_auto = 1'b0; manual_tx = 1'b0;
      req1_valid = 1'b1; req1_data = 8'h5A;
      step();
      check("t3_accept", {31'd0, hs1}, 1);
      req1_valid = 1'b0;
      n = 0;
      while (uart_transmit && n < 100) begin
        check($sformatf("t3_no_early_timeout%0d", n), {31'd0, tx_timeout}, 0);
        step();
        n++;
      end
      check("t3_start_cycles", n, TO);
      check("t3_timeout", {31'd0, tx_timeout}, 1);
      check("t3_idle", {31'd0, tx_busy}, 0);
      step();
      check("t3_sticky", {31'd0, tx_timeout}, 1);
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      check("t3_cleared", {31'd0, tx_timeout}, 0);
    end

    // Reset while DONE of 0xF0; next grant waits for is_transmitting to fall
    begin
      apply_reset();
      uart_auto = 1'b0; manual_tx = 1'b0;
      req0_valid = 1'b1; req0_data = 8'hF0;
      step();
      check("t6_accept", {31'd0, hs0}, 1);
      req0_valid = 1'b0;
      check("t6_transmit", {31'd0, uart_transmit}, 1);
      manual_tx = 1'b1;
      step();
      check("t6_done_transmit", {31'd0, uart_transmit}, 0);
      check("t6_done_busy", {31'd0, tx_busy}, 1);
      rst_n = 1'b0;
      #1;
      check("t6_async_busy", {31'd0, tx_busy}, 0);
      check("t6_async_transmit", {31'd0, uart_transmit}, 0);
      check("t6_async_tx_byte", {24'd0, uart_tx_byte}, 0);
      step();
      step();
      rst_n = 1'b1;
      req1_valid = 1'b1; req1_data = 8'h0F;
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("t6_hold%0d", k), {30'd0, hs1, uart_transmit}, 0);
      end
      manual_tx = 1'b0;
      step();
      check("t6_grant", {31'd0, hs1}, 1);
      req1_valid = 1'b0;
      check("t6_transmit2", {31'd0, uart_transmit}, 1);
      check("t6_tx_byte2", {24'd0, uart_tx_byte}, 32'h0F);
      manual_tx = 1'b1;
      step();
      check("t6_done2", {31'd0, uart_transmit}, 0);
      manual_tx = 1'b0;
      wait_idle("t6_idle");
      check("t6_byte_held", {24'd0, uart_tx_byte}, 32'h0F);
      uart_auto = 1'b1;
    end

    // Randomized streams from both requesters, round-robin order reference
    rand_frame = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int base, n0, n1, i0, i1, n, last, pick;
      apply_reset();
      b0.delete(); b1.delete(); exp_q.delete();
      n0 = $urandom_range(0, 6);
      n1 = $urandom_range(1, 6);
      for (int k = 0; k < n0; k++) b0.push_back(8'($urandom));
      for (int k = 0; k < n1; k++) b1.push_back(8'($urandom));
      i0 = 0; i1 = 0; last = 1;
      while (i0 < n0 || i1 < n1) begin
        if (i0 < n0 && i1 < n1) pick = 1 - last;
        else pick = (i0 < n0) ? 0 : 1;
        if (pick == 0) begin exp_q.push_back(b0[i0]); i0++; end
        else begin exp_q.push_back(b1[i1]); i1++; end
        last = pick;
      end
      base = tx_log.size();
      i0 = 0; i1 = 0; n = 0;
      while (!((i0 == n0) && (i1 == n1) && !tx_busy) && n < 2000) begin
        req0_valid = (i0 < n0);
        req0_data  = (i0 < n0) ? b0[i0] : 8'h00;
        req1_valid = (i1 < n1);
        req1_data  = (i1 < n1) ? b1[i1] : 8'h00;
        step();
        n++;
        if (hs0) i0++;
        if (hs1) i1++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check($sformatf("rnd%0d_done", r), {31'd0, (i0 == n0) && (i1 == n1) && !tx_busy}, 1);
      check($sformatf("rnd%0d_count", r), tx_log.size() - base, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
        if (tx_log.size() > base + k)
          check($sformatf("rnd%0d_byte%0d", r, k), {24'd0, tx_log[base + k]}, {24'd0, exp_q[k]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
